// File: rtl/mem_read_responder.sv
// ============================================================================
// mem_read_responder: serves CPU reads from a 17-word register file or a
// fixed-latency RAM, one outstanding request at a time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_read_responder #(
  parameter int RAM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [15:0]  req_addr,
  input  logic [271:0] reg_data,
  output logic         ram_en,
  output logic [15:0]  ram_addr,
  input  logic [15:0]  ram_rdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [15:0]  rsp_data,
  output logic [4:0]   rsp_src
);

  localparam logic [15:0] c_NUM_REGS = 16'd17;
  localparam logic [4:0]  c_SRC_RAM  = 5'd17;
  localparam logic [2:0]  c_LAT      = 3'(RAM_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RAM_WAIT = 2'd1,
    S_RESP     = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_cnt;

  logic        w_is_reg;
  logic [15:0] w_reg_word;

  assign w_is_reg   = (req_addr < c_NUM_REGS);
  // Only consulted when w_is_reg, so the index never exceeds word 16.
  assign w_reg_word = reg_data[{req_addr[4:0], 4'b0000} +: 16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      req_ready <= 1'b1;
      ram_en    <= 1'b0;
      ram_addr  <= 16'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'd0;
      rsp_src   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (w_is_reg) begin
              rsp_data  <= w_reg_word;
              rsp_src   <= req_addr[4:0];
              rsp_valid <= 1'b1;
              r_state   <= S_RESP;
            end else begin
              ram_addr <= req_addr;
              ram_en   <= 1'b1;
              r_cnt    <= 3'd0;
              r_state  <= S_RAM_WAIT;
            end
          end
        end
        S_RAM_WAIT: begin
          ram_en <= 1'b0;
          // The first edge here closes the strobe cycle; data is due
          // RAM_LATENCY edges after that.
          if (r_cnt == c_LAT) begin
            rsp_data  <= ram_rdata;
            rsp_src   <= c_SRC_RAM;
            rsp_valid <= 1'b1;
            r_cnt     <= 3'd0;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= 3'd0;
          req_ready <= 1'b1;
          ram_en    <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_read_responder.sv
// ============================================================================
// tb_mem_read_responder: random and directed reads against a transaction-level
// reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_read_responder;

  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [15:0]  req_addr = 16'd0;
  logic [271:0] reg_data = '0;
  logic         ram_en;
  logic [15:0]  ram_addr;
  logic [15:0]  ram_rdata = 16'd0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [15:0]  rsp_data;
  logic [4:0]   rsp_src;

  mem_read_responder #(.RAM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .reg_data(reg_data),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_src(rsp_src)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int valid_cycle = -1;
  logic [15:0] valid_addr = 16'd0;
  bit rand_reg = 1'b1;
  bit chk_en   = 1'b0;

  // Transaction-level model: where the one outstanding request stands.
  bit          m_resp, m_wait, m_ram_en;
  int          m_left;
  logic [15:0] m_ram_addr, m_rsp_data;
  logic [4:0]  m_rsp_src;

  function automatic logic [15:0] ram_model(input logic [15:0] a);
    logic [31:0] p;
    if (a == 16'h1234) return 16'hCAFE;
    p = 32'(a) * 32'h9E37;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_resp = 0; m_wait = 0; m_ram_en = 0; m_left = 0;
    m_ram_addr = 16'd0; m_rsp_data = 16'd0; m_rsp_src = 5'd0;
  endtask

  task automatic model_edge();
    int idx;
    if (m_resp) begin
      if (rsp_ready) m_resp = 0;
    end else if (m_wait) begin
      m_ram_en = 0;
      if (m_left == 1) begin
        m_wait = 0; m_resp = 1;
        m_rsp_data = ram_model(m_ram_addr);
        m_rsp_src = 5'd17;
      end else begin
        m_left--;
      end
    end else if (req_valid) begin
      if (req_addr < 16'd17) begin
        idx = int'(req_addr) * 16;
        m_resp = 1;
        m_rsp_data = reg_data[idx +: 16];
        m_rsp_src = req_addr[4:0];
      end else begin
        m_wait = 1; m_left = L + 1; m_ram_en = 1;
        m_ram_addr = req_addr;
      end
    end
  endtask

  // One clock: present inputs, advance the model, land on the next negedge.
  task automatic drive(input logic rv, input logic [15:0] ra, input logic rr);
    if (ram_en) begin
      valid_cycle = cyc + L;
      valid_addr  = ram_addr;
    end
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    if (rand_reg)
      for (int i = 0; i < 17; i++) reg_data[i*16 +: 16] = 16'($urandom);
    ram_rdata = (cyc == valid_cycle) ? ram_model(valid_addr) : 16'($urandom);
    if (rst_n) model_edge();
    else model_reset();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 12 && !req_ready; k++) drive(1'b0, 16'd0, 1'b1);
    check("idle_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ram_en"},    {31'd0, ram_en},    32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_ram_addr"},  {16'd0, ram_addr},  32'd0);
    check({tag, "_rsp_data"},  {16'd0, rsp_data},  32'd0);
    check({tag, "_rsp_src"},   {27'd0, rsp_src},   32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, !(m_resp || m_wait)});
      check("ram_en",    {31'd0, ram_en},    {31'd0, m_ram_en});
      check("ram_addr",  {16'd0, ram_addr},  {16'd0, m_ram_addr});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_resp});
      if (m_resp) begin
        check("rsp_data", {16'd0, rsp_data}, {16'd0, m_rsp_data});
        check("rsp_src",  {27'd0, rsp_src},  {27'd0, m_rsp_src});
      end
    end
  end

  initial begin
    logic [15:0] a;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_values("por");
    chk_en = 1'b1;
    @(negedge clk);
    drive(1'b1, 16'd5, 1'b1);
    drive(1'b1, 16'd20, 1'b1);
    rst_n = 1'b1;

    // Register read of word 5, accepted at the first edge out of reset
    rand_reg = 1'b0;
    reg_data[5*16 +: 16] = 16'hBEEF;
    drive(1'b1, 16'h0005, 1'b1);
    check("reg5_valid", {31'd0, rsp_valid}, 32'd1);
    check("reg5_data",  {16'd0, rsp_data},  32'h0000BEEF);
    check("reg5_src",   {27'd0, rsp_src},   32'd5);
    drive(1'b0, 16'd0, 1'b1);
    check("reg5_done", {31'd0, req_ready}, 32'd1);

    // Boundary 16 (last register) and 17 (first RAM address)
    reg_data[16*16 +: 16] = 16'h1616;
    drive(1'b1, 16'h0010, 1'b1);
    check("reg16_src",  {27'd0, rsp_src},  32'd16);
    check("reg16_data", {16'd0, rsp_data}, 32'h00001616);
    drive(1'b0, 16'd0, 1'b1);
    drive(1'b1, 16'h0011, 1'b1);
    check("a17_ram_en",   {31'd0, ram_en},    32'd1);
    check("a17_ram_addr", {16'd0, ram_addr},  32'h00000011);
    check("a17_no_rsp",   {31'd0, rsp_valid}, 32'd0);
    wait_idle();

    // RAM read with latency 2, then backpressure in RESP
    drive(1'b1, 16'h1234, 1'b1);
    check("ram_en_hi", {31'd0, ram_en}, 32'd1);
    drive(1'b0, 16'd0, 1'b1);
    check("ram_en_lo", {31'd0, ram_en}, 32'd0);
    drive(1'b1, 16'd3, 1'b1);
    check("ram_not_yet", {31'd0, rsp_valid}, 32'd0);
    drive(1'b1, 16'd3, 1'b0);
    check("ram_valid", {31'd0, rsp_valid}, 32'd1);
    check("ram_data",  {16'd0, rsp_data},  32'h0000CAFE);
    check("ram_src",   {27'd0, rsp_src},   32'd17);
    rand_reg = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'(i), 16'd2, 1'b0);
      check("stall_data",  {16'd0, rsp_data},  32'h0000CAFE);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    drive(1'b0, 16'd0, 1'b1);
    check("stall_done", {31'd0, rsp_valid}, 32'd0);

    // Reset one cycle after the RAM strobe
    drive(1'b1, 16'h2000, 1'b1);
    drive(1'b0, 16'd0, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1 check_reset_values("mid");
    drive(1'b1, 16'd3, 1'b1);
    rst_n = 1'b1;
    rand_reg = 1'b0;
    reg_data[3*16 +: 16] = 16'h3333;
    drive(1'b1, 16'd3, 1'b1);
    check("post_rst_src",  {27'd0, rsp_src},  32'd3);
    check("post_rst_data", {16'd0, rsp_data}, 32'h00003333);
    for (int i = 0; i < 6; i++) drive(1'b0, 16'd0, 1'b1);

    // Back-to-back: register read then RAM read of 16'hFFFF
    drive(1'b1, 16'd7, 1'b1);
    drive(1'b1, 16'hFFFF, 1'b1);
    check("b2b_gap_ready", {31'd0, req_ready}, 32'd1);
    check("b2b_gap_en",    {31'd0, ram_en},    32'd0);
    drive(1'b1, 16'hFFFF, 1'b1);
    check("b2b_ram_en",   {31'd0, ram_en},   32'd1);
    check("b2b_ram_addr", {16'd0, ram_addr}, 32'h0000FFFF);
    wait_idle();

    // Randomized traffic with occasional asynchronous resets
    rand_reg = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(0, 18));
        1: a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        drive(1'($urandom), a, 1'($urandom));
        rst_n = 1'b1;
      end else begin
        drive(1'($urandom), a, ($urandom_range(0, 9) < 7));
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_read_responder.md
MEM_READ_RESPONDER -- requirements
Module: mem_read_responder

Interface
REQ-001 Parameter RAM_LATENCY, default 1, range 1-4: cycles from the RAM enable cycle to the RAM read data being valid.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, named as below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  CPU read request valid.
REQ-006 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-007 req_addr  input  16  CPU read address.
REQ-008 reg_data  input  272  17 register words, 16 bits each; word i at bits [16i+15:16i].
REQ-009 ram_en  output  1  one-cycle RAM read strobe.
REQ-010 ram_addr  output  16  captured RAM read address.
REQ-011 ram_rdata  input  16  RAM read data.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  CPU accepts the response.
REQ-014 rsp_data  output  16  read data returned.
REQ-015 rsp_src  output  5  source of the data: 0-16 is the register index; 17 is RAM.

Function
REQ-016 State machine: IDLE, RAM_WAIT, RESP; reset state is IDLE.
REQ-017 Acceptance occurs at a rising edge when state is IDLE and req_valid=1.
REQ-018 Register-space read (req_addr < 17):
- At the accept edge, rsp_data <= reg_data word req_addr and rsp_src <= req_addr.
- State goes to RESP, so rsp_valid is high one cycle after acceptance.
REQ-019 RAM-space read (req_addr >= 17, including 16'hFFFF):
- At the accept edge, ram_addr <= req_addr, ram_en <= 1 and state goes to RAM_WAIT.
- ram_en stays high for exactly one cycle.
REQ-020 RAM_WAIT timing:
- A counter samples ram_rdata at the edge RAM_LATENCY cycles after the edge that ends the ram_en cycle.
- At that edge, rsp_data <= ram_rdata, rsp_src <= 17 and state goes to RESP.
REQ-021 RESP behaviour:
- rsp_valid=1.
- rsp_data and rsp_src are held stable until the edge where rsp_ready=1.
- At that edge, state goes to IDLE and rsp_valid goes to 0.
REQ-022 In RESP, rsp_ready=0 SHALL stall indefinitely with no change to outputs.
REQ-023 req_ready=0 in RAM_WAIT and RESP; req_valid is ignored there and is not queued.
REQ-024 rsp_ready asserted outside RESP SHALL have no effect.
REQ-025 Changes on reg_data after the accept edge SHALL NOT alter rsp_data.
REQ-026 ram_addr SHALL hold its last captured value until the next RAM-space acceptance.
REQ-027 Minimum transaction time: 2 cycles for a register read; 2+RAM_LATENCY cycles for a RAM read (with rsp_ready held at 1).

Reset
REQ-028 While rst_n=0, state and outputs SHALL take these values immediately, independent of clk:
- State: IDLE; counter: 0.
- rsp_valid=0, ram_en=0, rsp_data=0, rsp_src=0, ram_addr=0.
- req_ready=1.
REQ-029 No request SHALL be accepted while rst_n=0.
REQ-030 Reset asserted mid-transaction SHALL abort it:
- ram_en drops and any pending RAM data is discarded.
- No response is produced for the aborted request.
REQ-031 The first acceptance after reset SHALL be possible at the first rising edge with rst_n=1.

Verification
REQ-032 Register read: reg word 5=16'hBEEF, req_addr=16'h0005 accepted at edge N, rsp_ready=1 -> at N+1 rsp_valid=1, rsp_data=16'hBEEF, rsp_src=5; IDLE at N+2.
REQ-033 Boundary: req_addr=16'h0010 -> rsp_src=16, data from word 16; req_addr=16'h0011 -> ram_en=1 with ram_addr=16'h0011 and no register response.
REQ-034 RAM read with RAM_LATENCY=2: req_addr=16'h1234 accepted at edge N, RAM returns 16'hCAFE -> ram_en high during cycle N..N+1 only; rsp_valid=1, rsp_data=16'hCAFE, rsp_src=17 after edge N+3.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP while reg_data and req_valid toggle -> rsp_data, rsp_src and rsp_valid stay constant and req_ready=0; completion occurs at the first edge with rsp_ready=1.
REQ-036 Reset mid-RAM_WAIT: rst_n=0 one cycle after ram_en -> all outputs at reset values at once; after release, a new read of address 3 completes normally and no stale RAM data appears.
REQ-037 Back-to-back: a register read then a RAM read (16'hFFFF) with rsp_ready=1 -> the second is accepted exactly one cycle after the first response completes, and the responses come out in order.
